// File: rtl/add_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and nibble width.
package add_pkg;
  localparam int unsigned NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/add_nibble_cla.sv
// Purely combinational 4-bit generate/propagate carry-lookahead adder.
module add_nibble_cla
  import add_pkg::*;
(
  output logic                co,
  output logic [NIBBLE_W-1:0] s,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead terms; no carry ripples through the nibble.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[NIBBLE_W-1:0];
  assign co = c[NIBBLE_W];

endmodule

// File: rtl/add_serial_ctrl.sv
// Nibble-serial wide adder: one request in, NIB single-nibble CLA steps, one result out.
// Optional subtract mode (in_sub port) when ADD_SERIAL_SUB_EN is defined.
module add_serial_ctrl
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
`ifdef ADD_SERIAL_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  logic [1:0]          state_q;
  logic [1:0]          state_nxt;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;

  logic                last_c;
  logic [WIDTH-1:0]    b_in_c;
  logic                ci_in_c;
  logic [NIBBLE_W-1:0] nib_s_c;
  logic                nib_co_c;

  // Subtraction stores ~B and forces carry-in so the adder computes A + ~B + 1.
`ifdef ADD_SERIAL_SUB_EN
  assign b_in_c  = in_sub ? ~in_b : in_b;
  assign ci_in_c = in_sub | in_ci;
`else
  assign b_in_c  = in_b;
  assign ci_in_c = in_ci;
`endif

  assign last_c = (idx_q == IDX_W'(NIB - 1));

  // Operand registers shift right each step, so the current nibble is always the low one.
  add_nibble_cla u_cla (
    .co (nib_co_c),
    .s  (nib_s_c),
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q)
  );

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last_c)    state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  // Datapath: capture on accept, one nibble step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_sum <= '0;
      out_co  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= b_in_c;
            carry_q <= ci_in_c;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          out_sum[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_s_c;
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          carry_q <= nib_co_c;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_c) out_co <= nib_co_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Scoreboard bench for add_serial_ctrl (WIDTH=16); subtract vectors run when ADD_SERIAL_SUB_EN is defined.
module tb_add_serial_ctrl;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_ci = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             busy;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_edge = -1;
  logic ov_prev = 1'b0;

  add_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
`ifdef ADD_SERIAL_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on each out_valid rise, scoreboard compare on each output handshake.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) acc_edge = cyc + 1;
    if (out_valid && !ov_prev) check("latency", 32'(cyc - acc_edge), 32'd4);
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", 32'(out_sum), 32'(e.sum));
        check("co", 32'(out_co), 32'(e.co));
      end
    end
  end

  // Present a request, wait for acceptance, push expectation; returns #1 after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                       input logic sub, input logic [WIDTH-1:0] esum, input logic eco,
                       input logic keep_valid);
    bit ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    exp_q.push_back('{sum: esum, co: eco});
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int e0, e1, e2;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_co", 32'(out_co), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add, then in_ready one cycle after the output handshake.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
    wait_out_valid("ov_timeout_basic");
    @(posedge clk); #1;
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
    check("ov_after_hs", 32'(out_valid), 32'd0);

    // Full carry ripple across all nibble steps.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_out_valid("ov_timeout_ripple1");
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_out_valid("ov_timeout_ripple2");

    // Backpressure: result held, stray in_valid pulses ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    wait_out_valid("ov_timeout_bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0); in_a = 16'hAAAA; in_b = 16'h5555;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(out_sum), 32'h1000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset during the second RUN cycle aborts the operation.
    issue(16'h7777, 16'h1111, 1'b0, 1'b0, 16'h8888, 1'b0, 1'b0);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    wait_out_valid("ov_timeout_post_rst");
    @(posedge clk); #1;

    // Back-to-back with in_valid held high: accepts exactly NIB+2 = 6 cycles apart.
    issue(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1);
    e0 = acc_edge;
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b1);
    e1 = acc_edge;
    issue(16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    e2 = acc_edge;
    check("b2b_spacing1", 32'(e1 - e0), 32'd6);
    check("b2b_spacing2", 32'(e2 - e1), 32'd6);
    wait_out_valid("ov_timeout_b2b");
    @(posedge clk); #1;

`ifdef ADD_SERIAL_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    wait_out_valid("ov_timeout_sub1");
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    wait_out_valid("ov_timeout_sub2");
    issue(16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0);
    wait_out_valid("ov_timeout_sub0");
`endif

    // Drain: every pushed expectation consumed and no stray result left.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
